// File: rtl/riscv_pkg.sv
// riscv_pkg: encodings and types shared across the core.
// Holds funct3 load/store codes, mcause values and the LSU state enum.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] MCAUSE_ILLEGAL  = 4'd2;
  localparam logic [3:0] MCAUSE_LD_MIS   = 4'd4;
  localparam logic [3:0] MCAUSE_LD_FAULT = 4'd5;
  localparam logic [3:0] MCAUSE_ST_MIS   = 4'd6;
  localparam logic [3:0] MCAUSE_ST_FAULT = 4'd7;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } lsu_state_t;

  function automatic logic f3_legal(
    input logic [2:0] f3,
    input logic       store
  );
    if (store)
      return f3 inside {F3_SB, F3_SH, F3_SW};
    return f3 inside {F3_LB, F3_LH, F3_LW,
                      F3_LBU, F3_LHU};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane select, store replication and
// load lane extraction with sign/zero extension.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  sel,
  output logic [31:0] bus_wdata,
  output logic [31:0] rdata
);

  logic        is_byte;
  logic        is_half;
  logic        uns;
  logic [31:0] shifted;

  assign is_byte = funct3[1:0] == 2'b00;
  assign is_half = funct3[1:0] == 2'b01;
  assign uns     = funct3[2];
  assign shifted = bus_rdata >> {offset, 3'b000};

  always_comb begin
    sel       = 4'b1111;
    bus_wdata = wdata;
    rdata     = shifted;
    unique case (1'b1)
      is_byte: begin
        sel       = 4'b0001 << offset;
        bus_wdata = {4{wdata[7:0]}};
        rdata     = uns
          ? {24'b0, shifted[7:0]}
          : {{24{shifted[7]}}, shifted[7:0]};
      end
      is_half: begin
        sel       = 4'b0011 << offset;
        bus_wdata = {2{wdata[15:0]}};
        rdata     = uns
          ? {16'b0, shifted[15:0]}
          : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: RV32I load/store unit with a Wishbone data master.
// One access in flight; illegal/misaligned requests never reach the bus.
module lsu
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        kill_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic [31:0] mem_addr_o,
  output logic        e_ld_addr_mis_o,
  output logic        e_st_addr_mis_o,
  output logic        e_ld_acc_fault_o,
  output logic        e_st_acc_fault_o,
  output logic        e_illegal_inst_o,
  output logic [31:0] dwbm_addr_o,
  output logic [31:0] dwbm_dat_o,
  output logic [3:0]  dwbm_sel_o,
  output logic        dwbm_we_o,
  output logic        dwbm_cyc_o,
  output logic        dwbm_stb_o,
  input  logic [31:0] dwbm_dat_i,
  input  logic        dwbm_ack_i,
  input  logic        dwbm_err_i
);

  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_t  state;
  logic [2:0]  f3_q;
  logic        st_q;
  logic        killed;
  logic [CW-1:0] cnt;

  logic        accept;
  logic        legal;
  logic        mis;
  logic        timeout;
  logic        finish;
  logic        fault;
  logic        quiet;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_sel;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

  assign accept = state == IDLE && req_i &&
                  (is_load_i || is_store_i) && !kill_i;
  assign legal  = f3_legal(funct3_i, is_store_i);
  assign mis    = (funct3_i[1:0] == 2'b01 && addr_i[0]) ||
                  (funct3_i[1:0] == 2'b10 &&
                   addr_i[1:0] != 2'b00);
  assign stall_o = !rst_i && (accept || state == BUSY);

  assign timeout = cnt == CW'(TIMEOUT - 1);
  assign finish  = dwbm_ack_i || dwbm_err_i || timeout;
  // ack beats a simultaneous timeout; err always faults
  assign fault   = dwbm_err_i || !dwbm_ack_i;
  assign quiet   = killed || kill_i;

  // request fields in IDLE, latched ones while on the bus
  assign al_f3  = state == IDLE ? funct3_i : f3_q;
  assign al_off = state == IDLE ? addr_i[1:0]
                                : mem_addr_o[1:0];

  lsu_align u_align (
    .funct3    (al_f3),
    .offset    (al_off),
    .wdata     (wdata_i),
    .bus_rdata (dwbm_dat_i),
    .sel       (al_sel),
    .bus_wdata (al_wdata),
    .rdata     (al_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= IDLE;
      f3_q             <= '0;
      st_q             <= 1'b0;
      killed           <= 1'b0;
      cnt              <= '0;
      done_o           <= 1'b0;
      rdata_o          <= '0;
      mem_addr_o       <= '0;
      e_ld_addr_mis_o  <= 1'b0;
      e_st_addr_mis_o  <= 1'b0;
      e_ld_acc_fault_o <= 1'b0;
      e_st_acc_fault_o <= 1'b0;
      e_illegal_inst_o <= 1'b0;
      dwbm_addr_o      <= '0;
      dwbm_dat_o       <= '0;
      dwbm_sel_o       <= '0;
      dwbm_we_o        <= 1'b0;
      dwbm_cyc_o       <= 1'b0;
      dwbm_stb_o       <= 1'b0;
    end else begin
      done_o           <= 1'b0;
      e_ld_addr_mis_o  <= 1'b0;
      e_st_addr_mis_o  <= 1'b0;
      e_ld_acc_fault_o <= 1'b0;
      e_st_acc_fault_o <= 1'b0;
      e_illegal_inst_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            f3_q       <= funct3_i;
            st_q       <= is_store_i;
            killed     <= 1'b0;
            cnt        <= '0;
            mem_addr_o <= addr_i;
            if (!legal) begin
              state            <= DONE;
              done_o           <= 1'b1;
              rdata_o          <= '0;
              e_illegal_inst_o <= 1'b1;
            end else if (mis) begin
              state           <= DONE;
              done_o          <= 1'b1;
              rdata_o         <= '0;
              e_st_addr_mis_o <= is_store_i;
              e_ld_addr_mis_o <= !is_store_i;
            end else begin
              state       <= BUSY;
              dwbm_cyc_o  <= 1'b1;
              dwbm_stb_o  <= 1'b1;
              dwbm_we_o   <= is_store_i;
              dwbm_addr_o <= {addr_i[31:2], 2'b00};
              dwbm_sel_o  <= al_sel;
              dwbm_dat_o  <= al_wdata;
            end
          end
        end
        BUSY: begin
          if (kill_i)
            killed <= 1'b1;
          if (finish) begin
            state      <= DONE;
            cnt        <= '0;
            dwbm_cyc_o <= 1'b0;
            dwbm_stb_o <= 1'b0;
            dwbm_we_o  <= 1'b0;
            done_o     <= !quiet;
            rdata_o    <= (!fault && !st_q) ? al_rdata : '0;
            e_ld_acc_fault_o <= !quiet && fault && !st_q;
            e_st_acc_fault_o <= !quiet && fault && st_q;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed and randomised scoreboard bench for lsu.
// Bus slave behaviour is driven by hand inside each scenario task.
module tb_lsu;
  import riscv_pkg::*;

  typedef struct {
    logic        chk_rd;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [4:0]  exc;
  } exp_t;

  localparam logic [4:0] X_LD_MIS = 5'b10000;
  localparam logic [4:0] X_ST_MIS = 5'b01000;
  localparam logic [4:0] X_LD_ACC = 5'b00100;
  localparam logic [4:0] X_ST_ACC = 5'b00010;
  localparam logic [4:0] X_ILL    = 5'b00001;

  logic clk = 1'b0;
  logic rst, req, is_load, is_store, kill;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, dat_i;
  logic ack, err;
  logic stall, done;
  logic [31:0] rdata, mem_addr;
  logic ld_mis, st_mis, ld_acc, st_acc, ill;
  logic [31:0] wb_addr, wb_dat;
  logic [3:0]  wb_sel;
  logic wb_we, wb_cyc, wb_stb;
  logic [4:0] exc;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign exc = {ld_mis, st_mis, ld_acc, st_acc, ill};

  lsu #(.TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req),
    .is_load_i(is_load), .is_store_i(is_store),
    .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
    .kill_i(kill), .stall_o(stall), .done_o(done),
    .rdata_o(rdata), .mem_addr_o(mem_addr),
    .e_ld_addr_mis_o(ld_mis), .e_st_addr_mis_o(st_mis),
    .e_ld_acc_fault_o(ld_acc), .e_st_acc_fault_o(st_acc),
    .e_illegal_inst_o(ill),
    .dwbm_addr_o(wb_addr), .dwbm_dat_o(wb_dat),
    .dwbm_sel_o(wb_sel), .dwbm_we_o(wb_we),
    .dwbm_cyc_o(wb_cyc), .dwbm_stb_o(wb_stb),
    .dwbm_dat_i(dat_i), .dwbm_ack_i(ack), .dwbm_err_i(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic st,
                       input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] wd);
    req = 1'b1; is_load = ld; is_store = st;
    funct3 = f3; addr = a; wdata = wd;
  endtask

  function automatic logic [31:0] ld_model(
    input logic [2:0] f3, input logic [1:0] off,
    input logic [31:0] d);
    int sh;
    logic [7:0] b;
    logic [15:0] h;
    sh = int'(off);
    b = d[sh*8 +: 8];
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      F3_LB:   return {{24{b[7]}}, b};
      F3_LBU:  return {24'b0, b};
      F3_LH:   return {{16{h[15]}}, h};
      F3_LHU:  return {16'b0, h};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] sel_model(
    input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; req = 0; is_load = 0; is_store = 0;
    kill = 0; funct3 = 0; addr = 0; wdata = 0;
    dat_i = 0; ack = 0; err = 0;
    repeat (3) step();
    n_chk++;
    if ({done, stall, rdata, mem_addr, exc, wb_addr, wb_dat,
         wb_sel, wb_we, wb_cyc, wb_stb} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: done=%b cyc=%b rdata=%h addr=%h want all 0",
               done, wb_cyc, rdata, mem_addr);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_lw();
    exp_t e;
    sb.push_back('{1'b1, 32'hDEADBEEF, 32'h100, 5'b0});
    issue(1, 0, F3_LW, 32'h100, 0);
    #1;
    n_chk++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL lw_stall_accept: stall=%b want 1", stall);
    end
    step(); req = 0;
    n_chk++;
    if ({wb_cyc, wb_stb, wb_we, wb_sel, wb_addr} !==
        {1'b1, 1'b1, 1'b0, 4'b1111, 32'h100}) begin
      n_fail++;
      $display("FAIL lw_bus: cyc=%b stb=%b we=%b sel=%b addr=%h want 1 1 0 1111 100",
               wb_cyc, wb_stb, wb_we, wb_sel, wb_addr);
    end
    ack = 1; dat_i = 32'hDEADBEEF;
    step(); ack = 0;
    n_chk++;
    if (done !== 1'b1 || stall !== 1'b0) begin
      n_fail++; $display("FAIL lw_latency: done=%b stall=%b want 1 0", done, stall);
    end
    e = sb.pop_front();
    n_chk++;
    if (rdata !== e.rdata || {mem_addr, exc} !== {e.addr, e.exc}) begin
      n_fail++;
      $display("FAIL lw_result: rdata=%h addr=%h exc=%b want %h %h %b",
               rdata, mem_addr, exc, e.rdata, e.addr, e.exc);
    end
    step();
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL lw_done_pulse: done=%b want 0", done);
    end
  endtask

  task automatic test_lb_lbu();
    exp_t e;
    sb.push_back('{1'b1, 32'hFFFFFF80, 32'h103, 5'b0});
    sb.push_back('{1'b1, 32'h00000080, 32'h103, 5'b0});
    for (int k = 0; k < 2; k++) begin
      issue(1, 0, k == 0 ? F3_LB : F3_LBU, 32'h103, 0);
      step(); req = 0;
      n_chk++;
      if (wb_sel !== 4'b1000) begin
        n_fail++; $display("FAIL lb_sel%0d: sel=%b want 1000", k, wb_sel);
      end
      ack = 1; dat_i = 32'h80FF0000;
      step(); ack = 0;
      e = sb.pop_front();
      n_chk++;
      if (done !== 1'b1 || rdata !== e.rdata ||
          {mem_addr, exc} !== {e.addr, e.exc}) begin
        n_fail++;
        $display("FAIL lb_result%0d: done=%b rdata=%h exc=%b want 1 %h %b",
                 k, done, rdata, exc, e.rdata, e.exc);
      end
      step();
    end
  endtask

  task automatic test_store();
    exp_t e;
    sb.push_back('{1'b0, 32'h0, 32'h202, 5'b0});
    issue(0, 1, F3_SH, 32'h202, 32'h0000ABCD);
    step(); req = 0;
    n_chk++;
    if ({wb_dat, wb_sel, wb_we, wb_addr} !==
        {32'hABCDABCD, 4'b1100, 1'b1, 32'h200}) begin
      n_fail++;
      $display("FAIL sh_bus: dat=%h sel=%b we=%b addr=%h want abcdabcd 1100 1 200",
               wb_dat, wb_sel, wb_we, wb_addr);
    end
    ack = 1; step(); ack = 0;
    e = sb.pop_front();
    n_chk++;
    if (done !== 1'b1 || {mem_addr, exc} !== {e.addr, e.exc}) begin
      n_fail++;
      $display("FAIL sh_done: done=%b addr=%h exc=%b want 1 %h %b",
               done, mem_addr, exc, e.addr, e.exc);
    end
    step();
    sb.push_back('{1'b0, 32'h0, 32'h201, X_ST_MIS});
    issue(0, 1, F3_SW, 32'h201, 32'h12345678);
    step(); req = 0;
    e = sb.pop_front();
    n_chk++;
    if (wb_cyc !== 1'b0 || done !== 1'b1 ||
        {mem_addr, exc} !== {e.addr, e.exc}) begin
      n_fail++;
      $display("FAIL sw_mis: cyc=%b done=%b addr=%h exc=%b want 0 1 %h %b",
               wb_cyc, done, mem_addr, exc, e.addr, e.exc);
    end
    step();
  endtask

  task automatic test_illegal();
    exp_t e;
    sb.push_back('{1'b0, 32'h0, 32'h40, X_ILL});
    sb.push_back('{1'b0, 32'h0, 32'h44, X_ILL});
    sb.push_back('{1'b0, 32'h0, 32'h45, X_LD_MIS});
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: issue(1, 0, 3'b011, 32'h40, 0);
        1: issue(1, 1, 3'b100, 32'h44, 0);
        default: issue(1, 0, F3_LHU, 32'h45, 0);
      endcase
      step(); req = 0;
      e = sb.pop_front();
      n_chk++;
      if (wb_cyc !== 1'b0 || done !== 1'b1 ||
          {mem_addr, exc} !== {e.addr, e.exc}) begin
        n_fail++;
        $display("FAIL bad_req%0d: cyc=%b done=%b addr=%h exc=%b want 0 1 %h %b",
                 k, wb_cyc, done, mem_addr, exc, e.addr, e.exc);
      end
      step();
    end
  endtask

  task automatic test_err();
    exp_t e;
    sb.push_back('{1'b0, 32'h0, 32'h500, X_LD_ACC});
    issue(1, 0, F3_LW, 32'h500, 0);
    step(); req = 0;
    step(); step();
    n_chk++;
    if (wb_stb !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL err_hold: stb=%b done=%b want 1 0", wb_stb, done);
    end
    err = 1; step(); err = 0;
    e = sb.pop_front();
    n_chk++;
    if (done !== 1'b1 || wb_stb !== 1'b0 ||
        {mem_addr, exc} !== {e.addr, e.exc}) begin
      n_fail++;
      $display("FAIL err_fault: done=%b stb=%b exc=%b want 1 0 %b",
               done, wb_stb, exc, e.exc);
    end
    step();
  endtask

  task automatic test_timeout();
    exp_t e;
    int hi = 0;
    bit seen = 0;
    sb.push_back('{1'b0, 32'h0, 32'h300, X_ST_ACC});
    issue(0, 1, F3_SW, 32'h300, 32'h1);
    step(); req = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (wb_stb) hi++;
      if (done) seen = 1;
      else step();
    end
    e = sb.pop_front();
    n_chk++;
    if (!seen || hi != 4) begin
      n_fail++;
      $display("FAIL timeout_len: done_seen=%0d stb_cycles=%0d want 1 4", seen, hi);
    end
    n_chk++;
    if ({mem_addr, exc} !== {e.addr, e.exc}) begin
      n_fail++;
      $display("FAIL timeout_fault: addr=%h exc=%b want %h %b",
               mem_addr, exc, e.addr, e.exc);
    end
    step();
  endtask

  task automatic test_kill();
    issue(1, 0, F3_LW, 32'h400, 0);
    step(); req = 0;
    kill = 1; step(); kill = 0;
    n_chk++;
    if (wb_stb !== 1'b1 || wb_cyc !== 1'b1) begin
      n_fail++; $display("FAIL kill_hold: stb=%b cyc=%b want 1 1", wb_stb, wb_cyc);
    end
    step();
    ack = 1; dat_i = 32'h55AA55AA;
    step(); ack = 0;
    n_chk++;
    if (done !== 1'b0 || exc !== 5'b0 || wb_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_quiet: done=%b exc=%b stb=%b want 0 0 0", done, exc, wb_stb);
    end
    step();
  endtask

  task automatic test_rst_busy();
    exp_t e;
    issue(1, 0, F3_LW, 32'h600, 0);
    step(); req = 0;
    rst = 1; step(); rst = 0;
    n_chk++;
    if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy: cyc=%b stb=%b stall=%b want 0 0 0", wb_cyc, wb_stb, stall);
    end
    ack = 1; err = 1; step(); ack = 0; err = 0;
    n_chk++;
    if (done !== 1'b0 || exc !== 5'b0) begin
      n_fail++; $display("FAIL idle_ack: done=%b exc=%b want 0 0", done, exc);
    end
    sb.push_back('{1'b1, 32'h0BADF00D, 32'h604, 5'b0});
    issue(1, 0, F3_LW, 32'h604, 0);
    step(); req = 0;
    ack = 1; dat_i = 32'h0BADF00D;
    step(); ack = 0;
    e = sb.pop_front();
    n_chk++;
    if (done !== 1'b1 || rdata !== e.rdata || mem_addr !== e.addr) begin
      n_fail++;
      $display("FAIL rst_recover: done=%b rdata=%h want 1 %h", done, rdata, e.rdata);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [2:0] f3s [5] = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    exp_t e;
    logic [2:0] f3;
    logic [1:0] off;
    logic [31:0] d, a;
    for (int k = 0; k < 10; k++) begin
      f3 = f3s[$urandom_range(0, 4)];
      off = 2'($urandom_range(0, 3));
      if (f3[1:0] == 2'b01) off[0] = 1'b0;
      if (f3[1:0] == 2'b10) off = 2'b00;
      a = {$urandom_range(0, 65535), 14'b0, off};
      d = $urandom;
      sb.push_back('{1'b1, ld_model(f3, off, d), a, 5'b0});
      issue(1, 0, f3, a, 0);
      step();
      // keep req high with junk fields; must be ignored
      issue(1, 0, 3'b010, ~a, 0);
      n_chk++;
      if (wb_sel !== sel_model(f3, off) ||
          wb_addr !== {a[31:2], 2'b00}) begin
        n_fail++;
        $display("FAIL b2b_bus%0d: sel=%b addr=%h want %b %h",
                 k, wb_sel, wb_addr, sel_model(f3, off), {a[31:2], 2'b00});
      end
      ack = 1; dat_i = d;
      step(); ack = 0;
      e = sb.pop_front();
      n_chk++;
      if (done !== 1'b1 || stall !== 1'b0 || rdata !== e.rdata ||
          {mem_addr, exc} !== {e.addr, e.exc}) begin
        n_fail++;
        $display("FAIL b2b_result%0d: done=%b stall=%b rdata=%h addr=%h want 1 0 %h %h",
                 k, done, stall, rdata, mem_addr, e.rdata, e.addr);
      end
      step();
    end
    req = 0;
    step();
    n_chk++;
    if (sb.size() != 0 || wb_cyc !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_drain: left=%0d cyc=%b want 0 0", sb.size(), wb_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb_lbu();
    test_store();
    test_illegal();
    test_err();
    test_timeout();
    test_kill();
    test_rst_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the number of bus cycles without ack/err after which the access is aborted as a fault.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req_i  input  1  memory-access request from execute, qualified by is_load_i/is_store_i.
REQ-005 SHALL have ports is_load_i, is_store_i  input  1 each  access kind; both high is treated as store.
REQ-006 SHALL have port funct3_i  input  3  RV32I width/sign code (LB/LH/LW/LBU/LHU; SB/SH/SW).
REQ-007 SHALL have ports addr_i, wdata_i  input  32 each  effective address and store data.
REQ-008 SHALL have port kill_i  input  1  pipeline flush; suppresses completion of the current access.
REQ-009 SHALL have ports stall_o  output  1; done_o  output  1; rdata_o  output  32; mem_addr_o  output  32 (faulting/accessed address, feeds write-back mtval).
REQ-010 SHALL have exception outputs e_ld_addr_mis_o, e_st_addr_mis_o, e_ld_acc_fault_o, e_st_acc_fault_o, e_illegal_inst_o  output  1 each.
REQ-011 SHALL have Wishbone data master ports dwbm_addr_o[32], dwbm_dat_o[32], dwbm_sel_o[4], dwbm_we_o, dwbm_cyc_o, dwbm_stb_o (outputs); dwbm_dat_i[32], dwbm_ack_i, dwbm_err_i (inputs).

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE; IDLE->BUSY on accepted valid access, BUSY->DONE on ack/err/timeout, DONE->IDLE unconditionally, IDLE->DONE on misaligned/illegal request.
REQ-013 SHALL accept a request only in IDLE with req_i=1, (is_load_i|is_store_i)=1 and kill_i=0.
REQ-014 SHALL flag misalignment: halfword with addr[0]=1, word with addr[1:0]!=0; no bus cycle is started.
REQ-015 SHALL flag e_illegal_inst_o for funct3 011/110/111 (load) or 011-111 (store); no bus cycle.
REQ-016 SHALL register dwbm_cyc_o=dwbm_stb_o=1 the cycle after acceptance and hold addr/dat/sel/we stable until ack, err or timeout.
REQ-017 SHALL drive dwbm_addr_o = {addr[31:2],2'b00}; dwbm_sel_o = 0001<<addr[1:0] (byte), 0011<<addr[1:0] (half), 1111 (word).
REQ-018 SHALL replicate store data across lanes: byte x4, halfword x2, word as-is.
REQ-019 SHALL extract the load lane from dwbm_dat_i by addr[1:0] and sign-extend (LB/LH) or zero-extend (LBU/LHU) to 32 bits, latched on ack.
REQ-020 SHALL pulse done_o for exactly one cycle in DONE with rdata_o, mem_addr_o=addr_i of the access, and at most one exception flag valid in the same cycle.
REQ-021 SHALL assert stall_o combinationally from acceptance through BUSY; stall_o=0 in DONE and IDLE-without-request.
REQ-022 SHALL map dwbm_err_i to the access-fault flag of the access kind.
REQ-023 SHALL count BUSY cycles; at count=TIMEOUT drop cyc/stb and report access fault.
REQ-024 SHALL, on kill_i during BUSY, finish the Wishbone cycle (never drop stb before ack/err) but force done_o and all exception flags to 0 in the following DONE.
REQ-025 SHALL ignore a new req_i while in BUSY or DONE; ack/err received outside BUSY are ignored.
REQ-026 SHALL give a latency of 2 cycles from acceptance to done_o for zero-wait-state ack, 1 cycle for misaligned/illegal.

Reset
REQ-027 SHALL on rst_i=1 enter IDLE at the next edge, including mid-BUSY, dropping cyc/stb/we without waiting for ack.
REQ-028 SHALL reset all outputs to 0: done_o, stall_o, rdata_o, mem_addr_o, exception flags, all dwbm_* outputs, timeout counter.

Structure
REQ-029 SHALL take funct3 load/store encodings, mcause codes and the FSM state enum from the shared core package riscv_pkg.
REQ-030 SHALL place lane select, store replication and load extension in one combinational sub-module lsu_align.

Verification
REQ-031 LW addr 0x100, ack next cycle with dat 0xDEADBEEF -> done_o 2 cycles after req, rdata_o=0xDEADBEEF, sel=1111.
REQ-032 LB addr 0x103, dat_i 0x80FF0000 -> sel=1000, rdata_o=0xFFFFFF80; LBU same -> 0x00000080.
REQ-033 SH addr 0x202 wdata 0x0000ABCD -> dat_o=0xABCDABCD, sel=1100, we=1; SW addr 0x201 -> no cyc, e_st_addr_mis_o=1, mem_addr_o=0x201.
REQ-034 LW with dwbm_err_i=1 on 3rd BUSY cycle -> e_ld_acc_fault_o=1; no ack with TIMEOUT=4 -> stb drops after 4 cycles, fault flagged.
REQ-035 kill_i mid-BUSY then ack -> stb held until ack, done_o=0; rst_i mid-BUSY -> cyc/stb=0 next cycle, FSM IDLE.
